// File: rtl/block_field_painter.sv
// Breakout block-field painter: double-buffered per-row hit-count fetch over req/ack, 1-cycle pixel path.
// Define BLOCK_BEVEL_EN to draw block edges as a light (top/left) / dark (bottom/right) bevel instead of a gap.
module block_field_painter #(
   parameter int         BORDER_WIDTH   = 8,
   parameter int         BLOCK_WIDTH    = 48,
   parameter int         BLOCK_HEIGHT   = 16,
   parameter int         BLOCKS_PER_ROW = 13,
   parameter int         NUM_ROWS       = 16,
   parameter int         STATE_BITS     = 2,
   parameter logic [5:0] COLOR_L1       = 6'b001100,
   parameter logic [5:0] COLOR_L2       = 6'b110100,
   parameter logic [5:0] COLOR_L3       = 6'b110000
) (
   input  logic                                 clk,
   input  logic                                 rst,
   input  logic [9:0]                           hpos,
   input  logic [8:0]                           vpos,
   input  logic                                 new_frame,
   input  logic                                 new_line,
   output logic                                 row_req,
   output logic [$clog2(NUM_ROWS)-1:0]          row_addr,
   input  logic                                 row_ack,
   input  logic [BLOCKS_PER_ROW*STATE_BITS-1:0] row_data,
   output logic                                 block_en,
   output logic [5:0]                           color,
   output logic                                 underrun
);

   localparam int ROW_W = BLOCKS_PER_ROW * STATE_BITS;
   localparam int AW    = $clog2(NUM_ROWS);
   localparam int BXW   = $clog2(BLOCK_WIDTH);
   localparam int BYW   = $clog2(BLOCK_HEIGHT);
   localparam int CW    = $clog2(BLOCKS_PER_ROW + 1);

   localparam logic [9:0]     X_LO      = 10'(BORDER_WIDTH);
   localparam logic [9:0]     X_HI      = 10'(BORDER_WIDTH + BLOCKS_PER_ROW * BLOCK_WIDTH);
   localparam logic [8:0]     Y_LO      = 9'(BORDER_WIDTH);
   localparam logic [8:0]     Y_HI      = 9'(BORDER_WIDTH + NUM_ROWS * BLOCK_HEIGHT);
   localparam logic [BXW-1:0] BX_LAST   = BXW'(BLOCK_WIDTH - 1);
   localparam logic [BYW-1:0] BY_LAST   = BYW'(BLOCK_HEIGHT - 1);
   localparam logic [AW-1:0]  ADDR_LAST = AW'(NUM_ROWS - 1);

   typedef enum logic [1:0] {IDLE, FETCH, FULL} state_t;

   state_t                 state;
   logic [ROW_W-1:0]       next_buf, active_buf;
   logic                   flush_pending, flush_idle;
   logic [AW-1:0]          flush_addr, cur_addr, next_addr;
   logic                   addr_last;
   logic [BXW-1:0]         bx;
   logic [BYW-1:0]         by;
   logic [CW-1:0]          col;
   logic                   in_x, in_y, row_start, swap;
   logic [STATE_BITS-1:0]  h;
   logic                   edge_tl, edge_br, drawn;
   logic [5:0]             pal, pix;

   assign in_x      = (hpos >= X_LO) && (hpos < X_HI);
   assign in_y      = (vpos >= Y_LO) && (vpos < Y_HI);
   assign row_start = (vpos == Y_LO) || (by == BY_LAST);
   assign swap      = new_line && !new_frame && in_y && row_start;

   // While a flush is outstanding row_addr still shows the abandoned row; the real position is flush_addr.
   assign cur_addr  = flush_pending ? flush_addr : row_addr;
   assign addr_last = (cur_addr == ADDR_LAST);
   assign next_addr = addr_last ? cur_addr : cur_addr + 1'b1;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         bx  <= '0;
         col <= '0;
         by  <= '0;
      end else begin
         if (new_line) begin
            bx  <= '0;
            col <= '0;
         end else if (in_x) begin
            if (bx == BX_LAST) begin
               bx  <= '0;
               col <= col + 1'b1;
            end else begin
               bx <= bx + 1'b1;
            end
         end
         if (new_frame)
            by <= '0;
         else if (new_line && in_y)
            by <= row_start ? '0 : by + 1'b1;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state         <= IDLE;
         row_req       <= 1'b0;
         row_addr      <= '0;
         next_buf      <= '0;
         active_buf    <= '0;
         flush_pending <= 1'b0;
         flush_addr    <= '0;
         flush_idle    <= 1'b0;
         underrun      <= 1'b0;
      end else if (new_frame) begin
         active_buf <= '0;
         underrun   <= 1'b0;
         next_buf   <= '0;
         if (state == FETCH && !row_ack) begin
            flush_pending <= 1'b1;
            flush_addr    <= '0;
            flush_idle    <= 1'b0;
         end else begin
            row_addr      <= '0;
            state         <= FETCH;
            row_req       <= 1'b1;
            flush_pending <= 1'b0;
         end
      end else if (swap) begin
         if (state == FULL) begin
            active_buf <= next_buf;
            row_addr   <= next_addr;
            state      <= addr_last ? IDLE : FETCH;
            row_req    <= !addr_last;
         end else begin
            // Row not ready in time: show it blank and move on to the next row.
            active_buf <= '0;
            underrun   <= 1'b1;
            if (state == FETCH && !row_ack) begin
               flush_pending <= 1'b1;
               flush_addr    <= next_addr;
               flush_idle    <= addr_last;
            end else begin
               row_addr      <= next_addr;
               state         <= addr_last ? IDLE : FETCH;
               row_req       <= !addr_last;
               flush_pending <= 1'b0;
            end
         end
      end else if (state == FETCH && row_ack) begin
         if (flush_pending) begin
            flush_pending <= 1'b0;
            row_addr      <= flush_addr;
            state         <= flush_idle ? IDLE : FETCH;
            row_req       <= !flush_idle;
         end else begin
            next_buf <= row_data;
            state    <= FULL;
            row_req  <= 1'b0;
         end
      end
   end

   always_comb begin
      h = '0;
      for (int i = 0; i < BLOCKS_PER_ROW; i++)
         if (col == CW'(i)) h = active_buf[i*STATE_BITS +: STATE_BITS];
   end

   assign edge_tl = (bx == '0) || (by == '0);
   assign edge_br = (bx == BX_LAST) || (by == BY_LAST);
   assign pal     = (h == STATE_BITS'(1)) ? COLOR_L1 :
                    (h == STATE_BITS'(2)) ? COLOR_L2 : COLOR_L3;

`ifdef BLOCK_BEVEL_EN
   assign drawn = in_x && in_y && (h != '0);
   // Corners take the light treatment.
   assign pix   = edge_tl ? (pal | 6'b010101) :
                  edge_br ? {1'b0, pal[5], 1'b0, pal[3], 1'b0, pal[1]} : pal;
`else
   assign drawn = in_x && in_y && (h != '0) && !edge_tl && !edge_br;
   assign pix   = pal;
`endif

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         block_en <= 1'b0;
         color    <= '0;
      end else begin
         block_en <= drawn;
         color    <= drawn ? pix : 6'b0;
      end
   end

endmodule

// File: tb/tb_block_field_painter.sv
// Bench for block_field_painter: pixel vectors from a table pushed to a scoreboard, plus fetch corner sequences.
module tb_block_field_painter;

   localparam logic [5:0] L1 = 6'b001100;
   localparam logic [5:0] L2 = 6'b110100;
   localparam logic [5:0] L3 = 6'b110000;
`ifdef BLOCK_BEVEL_EN
   localparam logic       EE    = 1'b1;
   localparam logic [5:0] LT1   = 6'b011101;
   localparam logic [5:0] BR1   = 6'b000100;
   localparam logic [5:0] R2    = 6'b010000;
`else
   localparam logic       EE    = 1'b0;
   localparam logic [5:0] LT1   = 6'b000000;
   localparam logic [5:0] BR1   = 6'b000000;
   localparam logic [5:0] R2    = 6'b000000;
`endif

   logic        clk, rst;
   logic [9:0]  hpos;
   logic [8:0]  vpos;
   logic        new_frame, new_line;
   logic        row_req;
   logic [3:0]  row_addr;
   logic        row_ack;
   logic [25:0] row_data;
   logic        block_en;
   logic [5:0]  color;
   logic        underrun;

   block_field_painter dut (
      .clk(clk), .rst(rst), .hpos(hpos), .vpos(vpos),
      .new_frame(new_frame), .new_line(new_line),
      .row_req(row_req), .row_addr(row_addr), .row_ack(row_ack), .row_data(row_data),
      .block_en(block_en), .color(color), .underrun(underrun)
   );

   typedef struct {
      int         fr;
      int         x;
      int         y;
      logic       en;
      logic [5:0] col;
      string      name;
   } vec_t;

   typedef struct {
      int         due;
      logic       en;
      logic [5:0] col;
      string      name;
   } exp_t;

   vec_t        vec[$];
   exp_t        exp_q[$];
   logic [25:0] mem[16];
   int          cyc = 0;
   int          tests = 0;
   int          fails = 0;
   int          ack_lim = -1;
   int          ack_dly = 3;
   int          age = 0;

   initial clk = 1'b0;
   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   // Row memory responder: acks a pending request ack_dly cycles after it is seen, only for rows <= ack_lim.
   initial begin
      row_ack  = 1'b0;
      row_data = '0;
      forever begin
         @(posedge clk); #1;
         row_ack = 1'b0;
         if (row_req && int'(row_addr) <= ack_lim) begin
            if (age >= ack_dly) begin
               row_ack  = 1'b1;
               row_data = mem[row_addr];
               age      = 0;
            end else begin
               age++;
            end
         end else begin
            age = 0;
         end
      end
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic add(input int fr, input int x, input int y, input logic en, input logic [5:0] c,
                      input string n);
      vec_t v;
      v.fr = fr; v.x = x; v.y = y; v.en = en; v.col = c; v.name = n;
      vec.push_back(v);
   endtask

   // Pops due scoreboard entries at the negedge, then advances to just after the next posedge.
   task automatic step();
      exp_t e;
      @(negedge clk);
      while (exp_q.size() > 0 && exp_q[0].due <= cyc) begin
         e = exp_q.pop_front();
         chk(e.name, {25'b0, block_en, color}, {25'b0, e.en, e.col});
      end
      @(posedge clk); #1;
   endtask

   task automatic run_frame(input int fid, input int ylast, input logic nf);
      for (int y = 0; y <= ylast; y++) begin
         int hend;
         hend = 4;
         foreach (vec[i])
            if (vec[i].fr == fid && vec[i].y == y && vec[i].x + 1 > hend) hend = vec[i].x + 1;
         vpos      = 9'(y);
         hpos      = '0;
         new_line  = 1'b1;
         new_frame = nf && (y == 0);
         step();
         new_line  = 1'b0;
         new_frame = 1'b0;
         for (int x = 1; x <= hend; x++) begin
            hpos = 10'(x);
            foreach (vec[i])
               if (vec[i].fr == fid && vec[i].y == y && vec[i].x == x) begin
                  exp_t e;
                  e.due = cyc + 1; e.en = vec[i].en; e.col = vec[i].col; e.name = vec[i].name;
                  exp_q.push_back(e);
               end
            step();
         end
      end
   endtask

   initial begin
      rst = 1'b1; hpos = '0; vpos = '0; new_frame = 1'b0; new_line = 1'b0;
      for (int i = 0; i < 16; i++) mem[i] = '0;
      mem[0]  = 26'h3800001;   // block0 h=1, block11 h=2, block12 h=3
      mem[1]  = 26'h0000009;   // block0 h=1, block1 h=2
      mem[5]  = 26'h3FFFFFF;
      mem[15] = 26'h0000001;

      //  fr   x    y   en   colour  name
      add(1,   9,   9, 1'b1, L1,  "b0_h1");
      add(1,   8,   9, EE,   LT1, "x8_left");
      add(1,   9,   8, EE,   LT1, "y8_top");
      add(1,   8,   8, EE,   LT1, "corner_tl");
      add(1,  55,  23, EE,   BR1, "corner_br");
      add(1, 600,   9, 1'b1, L3,  "b12_h3");
      add(1, 580,   9, 1'b1, L2,  "b11_h2");
      add(1, 583,   9, EE,   R2,  "b11_right");
      add(1, 632,   9, 1'b0, 6'b0, "x_out");
      add(1,   9,  25, 1'b1, L1,  "r1_b0");
      add(1,  57,  25, 1'b1, L2,  "r1_b1");
      add(1,   9, 262, 1'b1, L1,  "r15_b0");
      add(1,   9, 263, EE,   BR1, "r15_bottom");
      add(1,   9, 264, 1'b0, 6'b0, "y_out");
      add(2,   9,   9, 1'b1, L1,  "ur_r0");
      add(2,   9,  25, 1'b0, 6'b0, "ur_r1_blank_b0");
      add(2,  57,  25, 1'b0, 6'b0, "ur_r1_blank_b1");
      add(3,   9,   9, 1'b1, L1,  "rec_r0");
      add(3,  57,  25, 1'b1, L2,  "rec_r1");
      add(4,   9,   9, 1'b1, L1,  "nf_row0");
      add(4,  57,   9, 1'b0, 6'b0, "nf_drop");

      repeat (2) @(posedge clk);
      #1;
      chk("rst_block_en", {31'b0, block_en}, 0);
      chk("rst_color",    {26'b0, color},    0);
      chk("rst_row_req",  {31'b0, row_req},  0);
      chk("rst_row_addr", {28'b0, row_addr}, 0);
      chk("rst_underrun", {31'b0, underrun}, 0);
      rst = 1'b0;
      step();

      // Reset while a fetch is outstanding.
      new_frame = 1'b1; new_line = 1'b1;
      step();
      new_frame = 1'b0; new_line = 1'b0;
      step(); step();
      chk("pre_rst_req", {31'b0, row_req}, 1);
      rst = 1'b1;
      #1;
      chk("mid_rst_row_req",  {31'b0, row_req},  0);
      chk("mid_rst_block_en", {31'b0, block_en}, 0);
      chk("mid_rst_underrun", {31'b0, underrun}, 0);
      chk("mid_rst_row_addr", {28'b0, row_addr}, 0);
      step();
      rst = 1'b0;
      step();

      // Full frame with timely fetches.
      ack_lim = 15;
      run_frame(1, 265, 1'b1);
      chk("f1_underrun", {31'b0, underrun}, 0);
      chk("f1_addr_sat", {28'b0, row_addr}, 15);
      chk("f1_idle_req", {31'b0, row_req},  0);

      // Row 1 never arrives: underrun and a blank row.
      ack_lim = 0;
      run_frame(2, 30, 1'b1);
      chk("f2_underrun_set", {31'b0, underrun}, 1);

      // Next frame clears underrun and recovers.
      ack_lim = 15;
      run_frame(3, 30, 1'b1);
      chk("f3_underrun_clr", {31'b0, underrun}, 0);

      // new_frame while row 5 is outstanding: late data dropped, row 0 re-requested.
      ack_lim = 4;
      run_frame(0, 80, 1'b1);
      chk("d_addr5",    {28'b0, row_addr}, 5);
      chk("d_req5",     {31'b0, row_req},  1);
      vpos = '0; hpos = '0; new_frame = 1'b1; new_line = 1'b1;
      step();
      new_frame = 1'b0; new_line = 1'b0;
      chk("d_flush_hold", {28'b0, row_addr}, 5);
      ack_lim = 15;
      for (int i = 0; i < 20 && row_addr != 4'd0; i++) step();
      chk("d_readdr0",  {28'b0, row_addr}, 0);
      chk("d_rereq",    {31'b0, row_req},  1);
      run_frame(4, 10, 1'b0);

      repeat (3) step();
      chk("sb_drained", exp_q.size(), 0);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
